apb_master: RTL

- APB initiator for the DMA subsystem. Converts single-beat register requests from a local command port (valid/ready) into APB SETUP/ACCESS transfers.
- Returns read data and error status on a response port.
- Drives the DMA configuration slave and any other APB register block: the testbench CPU model, and DMA self-test readback of mode/interrupt/LED registers.

---
 rtl/apb_master.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/apb_master.sv
// APB initiator: turns single-beat command-port requests into APB SETUP/ACCESS transfers.
// Optional ACCESS wait-state timeout is compiled in with `define APB_TIMEOUT_EN.
module apb_master #(
    parameter int REG_ADDR_WIDTH = 32,
    parameter int REG_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_cmd_valid,
    output logic                      out_cmd_ready,
    input  logic                      in_cmd_write,
    input  logic [REG_ADDR_WIDTH-1:0] in_cmd_addr,
    input  logic [REG_DATA_WIDTH-1:0] in_cmd_wdata,
    output logic                      out_rsp_valid,
    input  logic                      in_rsp_ready,
    output logic [REG_DATA_WIDTH-1:0] out_rsp_rdata,
    output logic                      out_rsp_err,
    output logic [REG_ADDR_WIDTH-1:0] out_m_apb_paddr,
    output logic                      out_m_apb_psel,
    output logic                      out_m_apb_penable,
    output logic                      out_m_apb_pwrite,
    output logic [REG_DATA_WIDTH-1:0] out_m_apb_pwdata,
    input  logic [REG_DATA_WIDTH-1:0] in_m_apb_prdata,
    input  logic                      in_m_apb_pready,
    input  logic                      in_m_apb_pslverr,
    output logic                      out_busy,
    output logic [1:0]                out_dbg_state
);

    // Handshakes: a command transfers on the rising edge where in_cmd_valid && out_cmd_ready,
    // a response on the edge where out_rsp_valid && in_rsp_ready; valid holds until transferred.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t                    state_q,     state_d;
    logic                      cmd_ready_q, cmd_ready_d;
    logic                      psel_q,      psel_d;
    logic                      penable_q,   penable_d;
    logic                      pwrite_q,    pwrite_d;
    logic [REG_ADDR_WIDTH-1:0] paddr_q,     paddr_d;
    logic [REG_DATA_WIDTH-1:0] pwdata_q,    pwdata_d;
    logic                      rsp_valid_q, rsp_valid_d;
    logic [REG_DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                      rsp_err_q,   rsp_err_d;
    logic                      busy_q,      busy_d;

`ifdef APB_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
    // Abort fires on the pready-less ACCESS cycle that would bring the count to TIMEOUT_CYCLES.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

    logic [WAIT_W-1:0] wait_q, wait_d;
`endif

    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        busy_d      = busy_q;
`ifdef APB_TIMEOUT_EN
        wait_d      = wait_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (in_cmd_valid && cmd_ready_q) begin
                    pwrite_d    = in_cmd_write;
                    paddr_d     = in_cmd_addr;
                    pwdata_d    = in_cmd_wdata;
                    psel_d      = 1'b1;
                    penable_d   = 1'b0;
                    cmd_ready_d = 1'b0;
                    busy_d      = 1'b1;
                    state_d     = ST_SETUP;
                end
            end

            ST_SETUP: begin
                penable_d = 1'b1;
                state_d   = ST_ACCESS;
`ifdef APB_TIMEOUT_EN
                wait_d    = '0;
`endif
            end

            ST_ACCESS: begin
                if (in_m_apb_pready) begin
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = pwrite_q ? '0 : in_m_apb_prdata;
                    rsp_err_d   = in_m_apb_pslverr;
                    state_d     = ST_RESP;
                end
`ifdef APB_TIMEOUT_EN
                else if (wait_q == WAIT_LAST) begin
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
`endif
            end

            ST_RESP: begin
                if (in_rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = ST_IDLE;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                cmd_ready_d = 1'b1;
                psel_d      = 1'b0;
                penable_d   = 1'b0;
                rsp_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    // Everything visible is a flop, so the async reset drops psel/penable immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b1;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
`ifdef APB_TIMEOUT_EN
            wait_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            busy_q      <= busy_d;
`ifdef APB_TIMEOUT_EN
            wait_q      <= wait_d;
`endif
        end
    end

    assign out_cmd_ready     = cmd_ready_q;
    assign out_rsp_valid     = rsp_valid_q;
    assign out_rsp_rdata     = rsp_rdata_q;
    assign out_rsp_err       = rsp_err_q;
    assign out_m_apb_paddr   = paddr_q;
    assign out_m_apb_psel    = psel_q;
    assign out_m_apb_penable = penable_q;
    assign out_m_apb_pwrite  = pwrite_q;
    assign out_m_apb_pwdata  = pwdata_q;
    assign out_busy          = busy_q;
    assign out_dbg_state     = state_q;

endmodule
